// File: rtl/prog_loader.sv
// prog_loader
// -----------
// Byte-stream program loader for the 16x8 program RAM. A frame arrives over a
// valid/ready byte interface as:
//   SYNC (8'hA5), header {start_addr[3:0], count_minus_1[3:0]},
//   count data bytes, checksum (8-bit sum of header and data bytes).
// Each data byte is written to RAM through a registered write port. The CPU
// core is held in reset (cpu_hold) from the SYNC byte until a frame with a
// good checksum completes. A bad checksum raises the sticky err flag and
// keeps the core held.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   s_valid   in   upstream byte valid
//   s_data    in   upstream byte [7:0]
//   s_ready   out  loader accepts a byte this cycle (decoded from state)
//   mem_addr  out  RAM write address [3:0] (registered)
//   mem_data  out  RAM write data [7:0] (registered)
//   mem_ld    out  RAM write strobe, high for one cycle per data byte
//   cpu_hold  out  core reset; high holds the core
//   busy      out  a frame is in progress
//   done      out  one-cycle pulse on a frame with a good checksum
//   err       out  sticky checksum error, cleared by the next SYNC

module prog_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_ld,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  addr;
  logic [4:0]  remaining;
  logic [7:0]  sum;
  logic        accept;

  assign accept = s_valid && s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. SYNC only has meaning in IDLE; inside a frame it is an
  // ordinary byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (s_data == SYNC)) state_next = HDR;
      HDR:     if (accept) state_next = DATA;
      DATA:    if (accept) state_next = WRITE;
      WRITE:   state_next = (remaining == 5'd0) ? CSUM : DATA;
      CSUM:    if (accept) state_next = (s_data == sum) ? DONE : IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. WRITE holds off the next data byte so the RAM strobe gets
  // its own cycle; DONE holds off the stream for the single done pulse.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    mem_ld  = 1'b0;
    case (state)
      IDLE:    s_ready = 1'b1;
      HDR: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      WRITE: begin
        busy   = 1'b1;
        mem_ld = 1'b1;
      end
      CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address/count/checksum tracking, RAM write port registers and
  // the core-hold / error flags. remaining is 5 bits because a header can
  // request 16 bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= 4'd0;
      remaining <= 5'd0;
      sum       <= 8'd0;
      mem_addr  <= 4'd0;
      mem_data  <= 8'd0;
      cpu_hold  <= 1'b1;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (s_data == SYNC)) begin
            cpu_hold <= 1'b1;
            err      <= 1'b0;
          end
        end
        HDR: begin
          if (accept) begin
            addr      <= s_data[7:4];
            remaining <= {1'b0, s_data[3:0]} + 5'd1;
            sum       <= s_data;
          end
        end
        DATA: begin
          if (accept) begin
            mem_addr  <= addr;
            mem_data  <= s_data;
            sum       <= sum + s_data;
            addr      <= addr + 4'd1;
            remaining <= remaining - 5'd1;
          end
        end
        CSUM: begin
          if (accept) begin
            if (s_data == sum) begin
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// --------------
// Self-checking bench for prog_loader. A negedge monitor mirrors the RAM that
// sits behind the write port and counts write strobes and done pulses. Each
// scenario task drives frames and compares the observed RAM image, strobe
// counts and flags against a frame-level reference model.

module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ld;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  int tests_run = 0;
  int failures  = 0;
  int ld_count  = 0;
  int done_count = 0;

  logic [7:0] mon_ram [16];
  logic [7:0] ref_ram [16];
  logic [7:0] frame_q [$];
  int         exp_writes;
  bit         exp_good;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ld   (mem_ld),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // RAM behind the write port plus pulse counters; also checks that the
  // stream is stalled during a write and that the core is released by done.
  always @(negedge clk) begin
    if (mem_ld === 1'b1) begin
      ld_count++;
      mon_ram[mem_addr] = mem_data;
      tests_run++;
      if (s_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL write_stall: s_ready=%0b during mem_ld, expected 0", s_ready);
      end
    end
    if (done === 1'b1) begin
      done_count++;
      tests_run++;
      if (cpu_hold !== 1'b0) begin
        failures++;
        $display("[TB] FAIL done_release: cpu_hold=%0b during done, expected 0", cpu_hold);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: RAM image and outcome of the frame in frame_q.
  task automatic model_frame();
    int start;
    int cnt;
    logic [7:0] s;
    start = int'(frame_q[1][7:4]);
    cnt   = int'(frame_q[1][3:0]) + 1;
    s     = frame_q[1];
    for (int i = 0; i < cnt; i++) begin
      ref_ram[(start + i) % 16] = frame_q[2 + i];
      s = s + frame_q[2 + i];
    end
    exp_writes = cnt;
    exp_good   = (frame_q[2 + cnt] == s);
  endtask

  // Present one byte (called at a negedge, returns at a negedge after the
  // transfer). Optional idle gaps carry random data with s_valid low.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    waited  = 0;
    while (s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL ready_timeout: s_ready=%0b after %0d cycles, expected 1", s_ready, waited);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    #1;
    tests_run += 8;
    if (s_ready !== 1'b1)  begin failures++; $display("[TB] FAIL reset_s_ready: got %0b expected 1", s_ready); end
    if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    if (done !== 1'b0)     begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    if (mem_ld !== 1'b0)   begin failures++; $display("[TB] FAIL reset_mem_ld: got %0b expected 0", mem_ld); end
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL reset_cpu_hold: got %0b expected 1", cpu_hold); end
    if (err !== 1'b0)      begin failures++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
    if (mem_addr !== 4'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    if (mem_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_mem_data: got %h expected 00", mem_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int ld0 = ld_count;
    int d0  = done_count;
    frame_q = {8'hA5, 8'h02, 8'h1E, 8'h2F, 8'h60, 8'hAF};
    model_frame();
    send_byte(8'hA5, 1'b0);
    tests_run += 2;
    if (busy !== 1'b1)     begin failures++; $display("[TB] FAIL good_busy: got %0b expected 1", busy); end
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL good_hold_sync: got %0b expected 1", cpu_hold); end
    for (int i = 1; i < 6; i++) send_byte(frame_q[i], 1'b0);
    repeat (3) @(negedge clk);
    tests_run += 8;
    if (mon_ram[0] !== 8'h1E) begin failures++; $display("[TB] FAIL good_ram0: got %h expected 1e", mon_ram[0]); end
    if (mon_ram[1] !== 8'h2F) begin failures++; $display("[TB] FAIL good_ram1: got %h expected 2f", mon_ram[1]); end
    if (mon_ram[2] !== 8'h60) begin failures++; $display("[TB] FAIL good_ram2: got %h expected 60", mon_ram[2]); end
    if (ld_count - ld0 !== 3) begin failures++; $display("[TB] FAIL good_writes: got %0d expected 3", ld_count - ld0); end
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL good_done: got %0d expected 1", done_count - d0); end
    if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL good_hold: got %0b expected 0", cpu_hold); end
    if (err !== 1'b0)      begin failures++; $display("[TB] FAIL good_err: got %0b expected 0", err); end
    if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL good_idle: busy=%0b expected 0", busy); end
  endtask

  task automatic test_wrap();
    int ld0 = ld_count;
    int d0  = done_count;
    frame_q = {8'hA5, 8'hE3, 8'h01, 8'h02, 8'h03, 8'h04, 8'hED};
    model_frame();
    send_frame(1'b0);
    tests_run += 6;
    if (mon_ram[14] !== 8'h01) begin failures++; $display("[TB] FAIL wrap_ram14: got %h expected 01", mon_ram[14]); end
    if (mon_ram[15] !== 8'h02) begin failures++; $display("[TB] FAIL wrap_ram15: got %h expected 02", mon_ram[15]); end
    if (mon_ram[0] !== 8'h03)  begin failures++; $display("[TB] FAIL wrap_ram0: got %h expected 03", mon_ram[0]); end
    if (mon_ram[1] !== 8'h04)  begin failures++; $display("[TB] FAIL wrap_ram1: got %h expected 04", mon_ram[1]); end
    if (ld_count - ld0 !== 4)  begin failures++; $display("[TB] FAIL wrap_writes: got %0d expected 4", ld_count - ld0); end
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL wrap_done: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_bad_checksum();
    int ld0 = ld_count;
    int d0  = done_count;
    frame_q = {8'hA5, 8'h02, 8'h1E, 8'h2F, 8'h60, 8'h00};
    model_frame();
    send_frame(1'b0);
    tests_run += 7;
    if (mon_ram[0] !== 8'h1E) begin failures++; $display("[TB] FAIL bad_ram0: got %h expected 1e", mon_ram[0]); end
    if (mon_ram[1] !== 8'h2F) begin failures++; $display("[TB] FAIL bad_ram1: got %h expected 2f", mon_ram[1]); end
    if (mon_ram[2] !== 8'h60) begin failures++; $display("[TB] FAIL bad_ram2: got %h expected 60", mon_ram[2]); end
    if (ld_count - ld0 !== 3) begin failures++; $display("[TB] FAIL bad_writes: got %0d expected 3", ld_count - ld0); end
    if (done_count - d0 !== 0) begin failures++; $display("[TB] FAIL bad_done: got %0d expected 0", done_count - d0); end
    if (err !== 1'b1)      begin failures++; $display("[TB] FAIL bad_err: got %0b expected 1", err); end
    if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL bad_hold: got %0b expected 1", cpu_hold); end
    // A following good frame clears err on SYNC and releases the core.
    d0 = done_count;
    frame_q = {8'hA5, 8'h02, 8'h1E, 8'h2F, 8'h60, 8'hAF};
    model_frame();
    send_byte(8'hA5, 1'b0);
    tests_run++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL bad_err_clear: got %0b expected 0", err); end
    for (int i = 1; i < 6; i++) send_byte(frame_q[i], 1'b0);
    repeat (3) @(negedge clk);
    tests_run += 3;
    if (err !== 1'b0)      begin failures++; $display("[TB] FAIL recover_err: got %0b expected 0", err); end
    if (cpu_hold !== 1'b0) begin failures++; $display("[TB] FAIL recover_hold: got %0b expected 0", cpu_hold); end
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL recover_done: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_garbage_sync();
    int ld0 = ld_count;
    int d0  = done_count;
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (ld_count - ld0 !== 0) begin failures++; $display("[TB] FAIL garbage_writes: got %0d expected 0", ld_count - ld0); end
    if (cpu_hold !== 1'b0)    begin failures++; $display("[TB] FAIL garbage_hold: got %0b expected 0", cpu_hold); end
    if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL garbage_busy: got %0b expected 0", busy); end
    frame_q = {8'hA5, 8'h00, 8'hA5, 8'hA5};
    model_frame();
    send_frame(1'b0);
    tests_run += 3;
    if (mon_ram[0] !== 8'hA5)  begin failures++; $display("[TB] FAIL insync_ram0: got %h expected a5", mon_ram[0]); end
    if (ld_count - ld0 !== 1)  begin failures++; $display("[TB] FAIL insync_writes: got %0d expected 1", ld_count - ld0); end
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL insync_done: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_gaps();
    int ld0 = ld_count;
    int d0  = done_count;
    frame_q = {8'hA5, 8'h02, 8'h1E, 8'h2F, 8'h60, 8'hAF};
    model_frame();
    send_frame(1'b1);
    tests_run += 5;
    if (mon_ram[0] !== 8'h1E) begin failures++; $display("[TB] FAIL gaps_ram0: got %h expected 1e", mon_ram[0]); end
    if (mon_ram[1] !== 8'h2F) begin failures++; $display("[TB] FAIL gaps_ram1: got %h expected 2f", mon_ram[1]); end
    if (mon_ram[2] !== 8'h60) begin failures++; $display("[TB] FAIL gaps_ram2: got %h expected 60", mon_ram[2]); end
    if (ld_count - ld0 !== 3) begin failures++; $display("[TB] FAIL gaps_writes: got %0d expected 3", ld_count - ld0); end
    if (done_count - d0 !== 1) begin failures++; $display("[TB] FAIL gaps_done: got %0d expected 1", done_count - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int ld0 = ld_count;
    int d0  = done_count;
    logic [7:0] rest [5] = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h6A};
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    ref_ram[0] = 8'h11;
    ref_ram[1] = 8'h22;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run += 7;
    if (s_ready !== 1'b1)   begin failures++; $display("[TB] FAIL midrst_s_ready: got %0b expected 1", s_ready); end
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
    if (mem_ld !== 1'b0)    begin failures++; $display("[TB] FAIL midrst_mem_ld: got %0b expected 0", mem_ld); end
    if (cpu_hold !== 1'b1)  begin failures++; $display("[TB] FAIL midrst_hold: got %0b expected 1", cpu_hold); end
    if (err !== 1'b0)       begin failures++; $display("[TB] FAIL midrst_err: got %0b expected 0", err); end
    if (mem_addr !== 4'h0)  begin failures++; $display("[TB] FAIL midrst_mem_addr: got %h expected 0", mem_addr); end
    if (mem_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_mem_data: got %h expected 00", mem_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    foreach (rest[i]) send_byte(rest[i], 1'b0);
    repeat (3) @(negedge clk);
    tests_run += 5;
    if (ld_count - ld0 !== 2)  begin failures++; $display("[TB] FAIL midrst_writes: got %0d expected 2", ld_count - ld0); end
    if (done_count - d0 !== 0) begin failures++; $display("[TB] FAIL midrst_done: got %0d expected 0", done_count - d0); end
    if (cpu_hold !== 1'b1)     begin failures++; $display("[TB] FAIL midrst_hold_after: got %0b expected 1", cpu_hold); end
    if (mon_ram[0] !== 8'h11)  begin failures++; $display("[TB] FAIL midrst_ram0: got %h expected 11", mon_ram[0]); end
    if (mon_ram[1] !== 8'h22)  begin failures++; $display("[TB] FAIL midrst_ram1: got %h expected 22", mon_ram[1]); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      int ld0 = ld_count;
      int d0  = done_count;
      int cnt;
      logic [7:0] hdr;
      logic [7:0] s;
      logic [7:0] b;
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b1);
      end
      hdr = 8'($urandom);
      cnt = int'(hdr[3:0]) + 1;
      s   = hdr;
      frame_q = {};
      frame_q.push_back(8'hA5);
      frame_q.push_back(hdr);
      for (int i = 0; i < cnt; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 3) == 0) frame_q.push_back(s ^ 8'($urandom_range(1, 255)));
      else                           frame_q.push_back(s);
      model_frame();
      send_frame(1'($urandom_range(0, 1)));
      tests_run += 4;
      if (ld_count - ld0 !== exp_writes) begin failures++; $display("[TB] FAIL rand%0d_writes: got %0d expected %0d", f, ld_count - ld0, exp_writes); end
      if (done_count - d0 !== (exp_good ? 1 : 0)) begin failures++; $display("[TB] FAIL rand%0d_done: got %0d expected %0d", f, done_count - d0, exp_good ? 1 : 0); end
      if (err !== !exp_good)      begin failures++; $display("[TB] FAIL rand%0d_err: got %0b expected %0b", f, err, !exp_good); end
      if (cpu_hold !== !exp_good) begin failures++; $display("[TB] FAIL rand%0d_hold: got %0b expected %0b", f, cpu_hold, !exp_good); end
      for (int a = 0; a < 16; a++) begin
        tests_run++;
        if (mon_ram[a] !== ref_ram[a]) begin
          failures++;
          $display("[TB] FAIL rand%0d_ram%0d: got %h expected %h", f, a, mon_ram[a], ref_ram[a]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      mon_ram[a] = 8'h00;
      ref_ram[a] = 8'h00;
    end
    test_reset();
    test_good_frame();
    test_wrap();
    test_bad_checksum();
    test_garbage_sync();
    test_gaps();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
